// File: rtl/pwd_serializer_if.sv
// Handshake bundle between the code-entry logic, the serializer and the serial password checker.
// The master modport is the serializer's view; slave is the environment (entry logic plus checker).
interface pwd_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] code_data;
  logic             code_valid;
  logic             code_ready;
  logic             serial_data;
  logic             serial_valid;
  logic             serial_ready;
  logic             unlock_in;
  logic             pwd_incorrect_in;

  modport master (
    input  code_data, code_valid, serial_ready, unlock_in, pwd_incorrect_in,
    output code_ready, serial_data, serial_valid
  );

  modport slave (
    output code_data, code_valid, serial_ready, unlock_in, pwd_incorrect_in,
    input  code_ready, serial_data, serial_valid
  );
endinterface

// File: rtl/pwd_serializer.sv
// Shifts a parallel code word MSB-first into the serial password checker and reports its verdict.
// Define PWD_SER_LOCKOUT_EN to enable failed-attempt counting and the timed lockout.
module pwd_serializer #(
  parameter int WIDTH          = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  pwd_serializer_if.master                  bus,
  output logic                              done,
  output logic                              granted,
  output logic                              denied,
  output logic                              locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_RESULT,
    ST_LOCKOUT
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             result_reg, result_next;
  logic             verdict;
  logic             lockout_entry;
  logic             lockout_exit;

  // Checker answers in the same beat; a dropped ready also counts as a verdict.
  assign verdict = bus.unlock_in | bus.pwd_incorrect_in | ~bus.serial_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      result_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.code_valid) begin
          shift_next = bus.code_data;
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (verdict) begin
          // Both unlock and incorrect together is illegal and treated as a denial.
          result_next = bus.unlock_in & ~bus.pwd_incorrect_in;
          state_next  = ST_RESULT;
        end else if (cnt_reg == CW'(WIDTH - 1)) begin
          result_next = 1'b0;
          state_next  = ST_RESULT;
        end else begin
          shift_next = shift_reg << 1;
          cnt_next   = cnt_reg + 1'b1;
        end
      end
      ST_RESULT: begin
        state_next = lockout_entry ? ST_LOCKOUT : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (lockout_exit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // All outputs decode registered state only, so nothing loops back through the checker.
  assign bus.code_ready   = (state_reg == ST_IDLE);
  assign bus.serial_valid = (state_reg == ST_SHIFT);
  assign bus.serial_data  = (state_reg == ST_SHIFT) & shift_reg[WIDTH-1];
  assign done             = (state_reg == ST_RESULT);
  assign granted          = done & result_reg;
  assign denied           = done & ~result_reg;

`ifdef PWD_SER_LOCKOUT_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  logic [AW-1:0] attempts_reg, attempts_next;
  logic [TW-1:0] timer_reg, timer_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attempts_reg <= AW'(MAX_ATTEMPTS);
      timer_reg    <= '0;
    end else begin
      attempts_reg <= attempts_next;
      timer_reg    <= timer_next;
    end
  end

  // A denial with one attempt left (or none) drops the counter to zero.
  assign lockout_entry = ~result_reg & (attempts_reg <= AW'(1));
  assign lockout_exit  = (timer_reg == TW'(1));

  always_comb begin
    attempts_next = attempts_reg;
    timer_next    = timer_reg;
    if (state_reg == ST_RESULT) begin
      if (result_reg) begin
        attempts_next = AW'(MAX_ATTEMPTS);
      end else if (attempts_reg != '0) begin
        attempts_next = attempts_reg - 1'b1;
      end
      if (lockout_entry) begin
        timer_next = TW'(LOCKOUT_CYCLES);
      end
    end else if (state_reg == ST_LOCKOUT) begin
      timer_next = timer_reg - 1'b1;
      if (lockout_exit) begin
        attempts_next = AW'(MAX_ATTEMPTS);
      end
    end
  end

  assign locked        = (state_reg == ST_LOCKOUT);
  assign attempts_left = attempts_reg;
`else
  assign lockout_entry = 1'b0;
  assign lockout_exit  = 1'b1;
  assign locked        = 1'b0;
  assign attempts_left = AW'(MAX_ATTEMPTS);
`endif
endmodule

// File: tb/tb_pwd_serializer.sv
// Directed bench for pwd_serializer with a behavioural model of the serial checker (password 1011).
module tb_pwd_serializer;
  localparam int WIDTH = 4;
  localparam int MAXA  = 3;
  localparam int LOCKC = 16;
  localparam logic [3:0] PWD = 4'b1011;
`ifdef PWD_SER_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done, granted, denied, locked;
  logic [1:0] attempts_left;

  // Checker model: mode 0 real checker, 1 silent (desync), 2 illegal unlock+incorrect.
  int         chk_mode = 0;
  logic [1:0] chk_idx;
  logic       chk_ready, chk_unlock, chk_incorrect;

  int n_checks = 0;
  int n_fail   = 0;

  pwd_serializer_if #(.WIDTH(WIDTH)) bus ();

  pwd_serializer #(
    .WIDTH(WIDTH), .MAX_ATTEMPTS(MAXA), .LOCKOUT_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done), .granted(granted), .denied(denied),
    .locked(locked), .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) chk_idx <= 2'd0;
    else if (!bus.serial_valid) chk_idx <= 2'd0;
    else chk_idx <= chk_idx + 2'd1;
  end

  always_comb begin
    chk_ready     = 1'b1;
    chk_unlock    = 1'b0;
    chk_incorrect = 1'b0;
    if (bus.serial_valid) begin
      if (chk_mode == 2) begin
        chk_unlock    = 1'b1;
        chk_incorrect = 1'b1;
      end else if (chk_mode == 0) begin
        if (bus.serial_data != PWD[2'd3 - chk_idx]) begin
          chk_incorrect = 1'b1;
          chk_ready     = 1'b0;
        end else if (chk_idx == 2'd3) begin
          chk_unlock = 1'b1;
        end
      end
    end
  end

  assign bus.serial_ready     = chk_ready;
  assign bus.unlock_in        = chk_unlock;
  assign bus.pwd_incorrect_in = chk_incorrect;

  function automatic int exp_att(input int a);
    return LOCK_EN ? a : MAXA;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [3:0] code;
    int         mode;
    bit         toggle;
    int         beats;
    bit         grant;
    int         att;
    bit         lock_after;
  } vec_t;

  vec_t vecs [9];

  // Entered and left at a falling edge; leaves off one cycle after the done pulse.
  task automatic run_attempt(input vec_t v, input int idx);
    int         n;
    int         beats;
    int         cyc;
    bit         got_done;
    logic [3:0] sent;
    logic [3:0] exp_sent;
    chk_mode = v.mode;
    n = 0;
    while (!bus.code_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("code_ready_before", int'(bus.code_ready), 1);
    bus.code_data  = v.code;
    bus.code_valid = 1'b1;
    @(negedge clk);
    bus.code_valid = 1'b0;
    beats = 0;
    cyc = 1;
    got_done = 1'b0;
    sent = 4'd0;
    while (cyc <= WIDTH + 3) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.serial_valid) begin
        sent = {sent[2:0], bus.serial_data};
        beats++;
      end
      if (v.toggle) begin
        bus.code_valid = cyc[0];
        bus.code_data  = ~v.code;
      end
      @(negedge clk);
      cyc++;
    end
    bus.code_valid = 1'b0;
    exp_sent = v.code >> (4 - v.beats);
    check("done_seen", int'(got_done), 1);
    check("beats", beats, v.beats);
    check("done_cycle", cyc, v.beats + 1);
    check("bits_sent", int'(sent), int'(exp_sent));
    check("granted", int'(granted), int'(v.grant));
    check("denied", int'(denied), int'(!v.grant));
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("serial_valid_after", int'(bus.serial_valid), 0);
    check("attempts_left", int'(attempts_left), exp_att(v.att));
    $display("attempt %0d code=%b beats=%0d granted=%0b denied_seen=%0b attempts_left=%0d",
             idx, v.code, beats, v.grant, !v.grant, attempts_left);
  endtask

  task automatic lockout_seq();
    int cnt;
    int n;
    bit leaked;
    bus.code_data  = PWD;
    bus.code_valid = 1'b1;
    cnt = 0;
    n = 0;
    leaked = 1'b0;
    while (locked && n < 40) begin
      if (bus.code_ready || bus.serial_valid) leaked = 1'b1;
      cnt++;
      n++;
      @(negedge clk);
    end
    bus.code_valid = 1'b0;
    check("lock_cycles", cnt, LOCK_EN ? LOCKC : 0);
    check("lock_ignored_code", int'(leaked), 0);
    check("ready_after_lock", int'(bus.code_ready), 1);
    check("attempts_after_lock", int'(attempts_left), MAXA);
    $display("lockout: locked for %0d cycles, attempts_left=%0d", cnt, attempts_left);
  endtask

  task automatic reset_mid_shift();
    int dones;
    int n;
    n = 0;
    chk_mode = 0;
    while (!bus.code_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.code_data  = PWD;
    bus.code_valid = 1'b1;
    @(negedge clk);
    bus.code_valid = 1'b0;
    @(negedge clk);
    check("second_bit_valid", int'(bus.serial_valid), 1);
    check("second_bit_value", int'(bus.serial_data), 0);
    reset = 1'b1;
    #1;
    check("reset_drops_valid", int'(bus.serial_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || bus.serial_valid) dones++;
      @(negedge clk);
    end
    check("no_done_after_reset", dones, 0);
    check("ready_after_reset", int'(bus.code_ready), 1);
    check("attempts_after_reset", int'(attempts_left), MAXA);
    $display("reset mid-shift: activity after release=%0d attempts_left=%0d", dones, attempts_left);
  endtask

  initial begin
    //        code     mode tog beats grant att lock
    vecs[0] = '{4'b1011, 0, 1'b0, 4, 1'b1, 3, 1'b0};
    vecs[1] = '{4'b0011, 0, 1'b0, 1, 1'b0, 2, 1'b0};
    vecs[2] = '{4'b1011, 0, 1'b1, 4, 1'b1, 3, 1'b0};
    vecs[3] = '{4'b1100, 0, 1'b0, 2, 1'b0, 2, 1'b0};
    vecs[4] = '{4'b1111, 0, 1'b0, 2, 1'b0, 1, 1'b0};
    vecs[5] = '{4'b1010, 0, 1'b0, 4, 1'b0, 0, 1'b1};
    vecs[6] = '{4'b0110, 1, 1'b0, 4, 1'b0, 2, 1'b0};
    vecs[7] = '{4'b1011, 2, 1'b0, 1, 1'b0, 1, 1'b0};
    vecs[8] = '{4'b1011, 0, 1'b0, 4, 1'b1, 3, 1'b0};

    bus.code_data  = 4'd0;
    bus.code_valid = 1'b0;
    #1;
    check("rst_serial_valid", int'(bus.serial_valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_code_ready", int'(bus.code_ready), 1);
    check("rst_serial_data", int'(bus.serial_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_granted", int'(granted), 0);
    check("rst_denied", int'(denied), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_attempts", int'(attempts_left), MAXA);
    $display("reset: code_ready=%0b attempts_left=%0d", bus.code_ready, attempts_left);

    for (int i = 0; i < 9; i++) begin
      run_attempt(vecs[i], i);
      if (vecs[i].lock_after) lockout_seq();
    end

    run_attempt(vecs[1], 9);
    reset_mid_shift();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
